wb_stage: RTL

- Write-back stage that consumes the MEM/WB pipeline register outputs and commits results to the register file, HI/LO and CP0.
- Completes loads whose data returns over the SRAM-like data bus with variable latency:
  - buffers early responses;
  - stalls the pipeline while a load waits;
  - drains orphaned responses after a flush.
- Extracts and extends load bytes and drives the debug trace port.

---
 rtl/wb_stage_pkg.sv | 19 +
 rtl/wb_load_ext.sv | 41 ++++
 rtl/wb_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: FSM states, load opcodes, bus widths.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_DONE  = 2'd2,
        WB_DRAIN = 2'd3
    } wb_state_e;

    localparam logic [7:0] ALUOP_LB  = 8'h90;
    localparam logic [7:0] ALUOP_LBU = 8'h91;
    localparam logic [7:0] ALUOP_LH  = 8'h92;
    localparam logic [7:0] ALUOP_LHU = 8'h93;
    localparam logic [7:0] ALUOP_LW  = 8'h94;

    localparam int BSEL_BUS = 4;

endpackage

// File: rtl/wb_load_ext.sv
// Byte/half/word select of returned load data, zero- or sign-extended by opcode.
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [BSEL_BUS-1:0] dre_i,
    input  logic [7:0]          aluop_i,
    output logic [DATA_W-1:0]   word_o
);

    logic uns;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        uns    = (aluop_i == ALUOP_LBU) || (aluop_i == ALUOP_LHU);
        b      = '0;
        h      = '0;
        word_o = '0;
        case (dre_i)
            4'b0001: b = rdata_i[7:0];
            4'b0010: b = rdata_i[15:8];
            4'b0100: b = rdata_i[23:16];
            4'b1000: b = rdata_i[31:24];
            4'b0011: h = rdata_i[15:0];
            4'b1100: h = rdata_i[31:16];
            default: ;
        endcase
        case (dre_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                word_o = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
            4'b0011, 4'b1100:
                word_o = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            4'b1111: word_o = rdata_i;
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/HI/LO/CP0 results, completes variable-latency loads
// (early-response buffer, stall while waiting, drain after flush) and drives the trace port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int EARLY_DEPTH = 1
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic [4:0]            wb_wa,
    input  logic                  wb_wreg,
    input  logic [DATA_W-1:0]     wb_dreg,
    input  logic                  wb_mreg,
    input  logic [BSEL_BUS-1:0]   wb_dre,
    input  logic                  wb_whilo,
    input  logic [2*DATA_W-1:0]   wb_hilo,
    input  logic [7:0]            wb_aluop,
    input  logic                  wb_cp0_we,
    input  logic [4:0]            wb_cp0_waddr,
    input  logic [DATA_W-1:0]     wb_cp0_wdata,
    input  logic [DATA_W-1:0]     wb_pc,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     data_rdata,
    input  logic                  data_data_ok,
    output logic                  rf_we,
    output logic [4:0]            rf_wa,
    output logic [DATA_W-1:0]     rf_wd,
    output logic                  hilo_we,
    output logic [2*DATA_W-1:0]   hilo_wd,
    output logic                  cp0_we,
    output logic [4:0]            cp0_waddr,
    output logic [DATA_W-1:0]     cp0_wdata,
    output logic                  stall_req_wb,
    output logic [DATA_W-1:0]     debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

    wb_state_e state_q, state_d;
    logic [DATA_W-1:0]      ld_q, ld_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [1:0][DATA_W-1:0] early_q, early_d;

    logic              commit, stall, pop, consume, push, drop;
    logic [DATA_W-1:0] src, ext;

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        commit  = 1'b0;
        stall   = 1'b0;
        pop     = 1'b0;
        consume = 1'b0;
        src     = data_rdata;
        case (state_q)
            WB_IDLE: begin
                if (!wb_mreg) begin
                    commit = 1'b1;
                end else if (cnt_q != 2'd0) begin
                    commit = 1'b1;
                    pop    = 1'b1;
                    src    = early_q[0];
                end else if (data_data_ok) begin
                    commit  = 1'b1;
                    consume = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = WB_WAIT;
                end
            end
            WB_WAIT: begin
                stall = !flush;
                if (data_data_ok) begin
                    consume = 1'b1;
                    if (flush) begin
                        state_d = WB_IDLE;
                    end else begin
                        ld_d    = data_rdata;
                        state_d = WB_DONE;
                    end
                end else if (flush) begin
                    state_d = WB_DRAIN;
                end
            end
            WB_DONE: begin
                commit  = 1'b1;
                src     = ld_q;
                state_d = WB_IDLE;
            end
            default: begin
                // The orphaned response cannot be told apart from a new load's data,
                // so loads hold here; non-loads keep flowing.
                commit = !wb_mreg;
                stall  = wb_mreg;
                if (data_data_ok) begin
                    consume = 1'b1;
                    state_d = WB_IDLE;
                end
            end
        endcase
    end

    // A response that no load is consuming yet belongs to a younger load still in MEM.
    assign push = data_data_ok && !consume && (state_q == WB_IDLE || state_q == WB_DONE);

    always_comb begin
        early_d = early_q;
        cnt_d   = cnt_q;
        drop    = 1'b0;
        if (pop) begin
            early_d[0] = early_q[1];
            cnt_d      = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d < 2'(EARLY_DEPTH)) begin
                early_d[cnt_d[0]] = data_rdata;
                cnt_d             = cnt_d + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
        if (flush) cnt_d = 2'd0;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= WB_IDLE;
            ld_q    <= '0;
            cnt_q   <= 2'd0;
            early_q <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            early_q <= early_d;
        end
    end

    no_early_overflow: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst) !(drop && !flush));

    wb_load_ext #(.DATA_W(DATA_W)) u_ext (
        .rdata_i (src),
        .dre_i   (wb_dre),
        .aluop_i (wb_aluop),
        .word_o  (ext)
    );

    logic live, cmt;
    assign live = !cpu_rst;
    assign cmt  = live && commit;

    assign rf_we        = cmt && wb_wreg && (wb_wa != 5'd0);
    assign rf_wa        = live ? wb_wa : 5'd0;
    assign rf_wd        = !live ? '0 : (wb_mreg ? ext : wb_dreg);
    assign hilo_we      = cmt && wb_whilo;
    assign hilo_wd      = live ? wb_hilo : '0;
    assign cp0_we       = cmt && wb_cp0_we;
    assign cp0_waddr    = live ? wb_cp0_waddr : 5'd0;
    assign cp0_wdata    = live ? wb_cp0_wdata : '0;
    assign stall_req_wb = live && stall;

    assign debug_wb_pc       = cmt ? wb_pc : '0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_wa;
    assign debug_wb_rf_wdata = rf_wd;

endmodule
